chaoent_health_pack: RTL and testbench
======================================

Name: chaoent_health_pack

Overview:
Downstream consumer of the chaotic entropy extractor's 4-bit raw samples (o_dat/o_valid).
Runs continuous online health tests on every sample: a repetition-count test (RCT) and an adaptive-proportion test (APT).
Gates output through a startup/run/fail state machine.
Packs accepted nibbles into OUT_WIDTH-bit words delivered on a valid/ready interface to the random-number consumer.

Parameters:
OUT_WIDTH, 32, output word width; multiple of 4, at least 8.
RCT_CUTOFF, 8, consecutive identical samples that trigger RCT failure.
APT_WINDOW, 64, APT window length in samples; power of 2.
APT_CUTOFF, 20, occurrences of the window reference sample that trigger APT failure.
STARTUP_SAMPLES, 128, samples that must pass the tests before output is enabled.

Ports:
i_clk  in  1  single clock; all logic on its rising edge.
i_reset_n  in  1  synchronous, active-low reset.
i_en  in  1  enable; when low, samples are ignored and all state is held.
i_dat  in  4  raw sample from the extractor.
i_valid  in  1  sample strobe, one cycle per sample; upstream has no backpressure.
i_clr_fail  in  1  single-cycle pulse; leaves FAIL and restarts.
i_ready  in  1  consumer accepts o_word when high together with o_valid.
o_word  out  OUT_WIDTH  packed random word.
o_valid  out  1  o_word is valid.
o_state  out  2  current state: 0=STARTUP, 1=RUN, 2=FAIL.
o_rct_fail  out  1  sticky RCT failure flag.
o_apt_fail  out  1  sticky APT failure flag.
o_overflow  out  1  sticky flag: a completed word was dropped.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-low on i_reset_n.
- Reset values: o_word=0, o_valid=0, o_state=STARTUP, all sticky flags 0, all counters 0. The first sample after reset is treated as the first sample of an APT window and starts the RCT.
- Sample acceptance: a sample is accepted when i_en && i_valid && state!=FAIL.
- RCT:
  - Compares each sample with the previous accepted sample.
  - Equal: count += 1 (saturating). Different: count = 1.
  - When the count reaches RCT_CUTOFF, o_rct_fail is set on the next edge.
- APT:
  - The window index wraps at 0..APT_WINDOW-1.
  - At index 0: reference = sample, count = 1.
  - Otherwise, count += 1 on a match with the reference.
  - When the count reaches APT_CUTOFF, o_apt_fail is set on the next edge.
  - The count restarts at the next window start.
- State transitions:
  - STARTUP -> RUN after STARTUP_SAMPLES accepted samples with no failure.
  - Any state -> FAIL in the same cycle a fail flag sets.
  - FAIL -> STARTUP on i_clr_fail. This clears both fail flags, o_overflow, all test counters and the packer. o_word is not cleared.
  - i_clr_fail outside FAIL is ignored.
- Test and packer participation by state:
  - STARTUP: samples feed the tests only, not the packer.
  - RUN: samples feed both.
  - FAIL: o_valid drops on the transition edge and any held word is discarded.
- Packer:
  - word <= {word[OUT_WIDTH-5:0], i_dat}, so the first nibble ends up in the MSBs.
  - On the (OUT_WIDTH/4)-th nibble, the completed word loads into o_word, with o_valid=1 on the next edge (latency 1 cycle).
  - The word loads only if the output register is empty or handed off (o_valid&&i_ready) in that same cycle.
  - Otherwise the completed word is dropped, o_overflow is set, and the nibble counter restarts.
- Handshake:
  - o_word is stable while o_valid && !i_ready.
  - The transfer occurs on an edge where o_valid && i_ready.
  - Load and accept in the same cycle: the new word replaces the old one and o_valid stays 1.
- Failing sample: a sample that causes a failure is not packed.
- i_en low: counters, packer and state hold. The output handshake still completes.

Decomposition:
- Shared package chaoent_pkg:
  - state enum (STARTUP, RUN, FAIL);
  - SAMPLE_W=4;
  - state encoding constants for o_state.
- Sub-module chaoent_health_test:
  - contains RCT and APT;
  - inputs: sample plus strobe, clear;
  - outputs: the two fail pulses.
- The parent holds the FSM, packer and output register.

Test Plan:
- Startup and first word: reset, then 128 samples cycling 0..15 -> o_state=RUN after the 128th. Then samples 1,2,3,4,5,6,7,8 -> o_word=0x12345678 and o_valid=1 one cycle after the 8th, held until i_ready.
- RCT failure: in RUN, 8 consecutive 0xA -> o_rct_fail=1, o_state=FAIL, o_valid=0. Further samples are ignored.
- APT failure: a window with reference 0x3 recurring every third sample, non-3 samples distinct from their neighbours -> o_apt_fail=1 at the 20th match, o_rct_fail stays 0.
- Backpressure: i_ready=0, 16 RUN samples -> first word held unchanged and second dropped, o_overflow=1. Then i_ready=1 -> first word transferred, o_valid=0.
- Recovery: in FAIL, pulse i_clr_fail -> o_state=STARTUP and all flags 0. No o_valid until another 128 samples plus 8 more.
- Reset mid-word: in RUN, 5 nibbles, then i_reset_n=0 for 1 cycle -> all outputs 0 and o_state=STARTUP. The first post-startup word contains only post-reset nibbles.

Source files
------------

// File: rtl/chaoent_pkg.sv
// Shared types and constants for the chaotic-entropy health/packing slice.
package chaoent_pkg;

  localparam int SAMPLE_W = 4;

  localparam logic [1:0] STATE_STARTUP = 2'd0;
  localparam logic [1:0] STATE_RUN     = 2'd1;
  localparam logic [1:0] STATE_FAIL    = 2'd2;

  typedef enum logic [1:0] {
    ST_STARTUP = STATE_STARTUP,
    ST_RUN     = STATE_RUN,
    ST_FAIL    = STATE_FAIL
  } chaoent_state_e;

endpackage

// File: rtl/chaoent_health_test.sv
// Repetition-count and adaptive-proportion tests on accepted samples.
// Fail outputs are same-cycle pulses for the sample being presented on strobe.
module chaoent_health_test
  import chaoent_pkg::*;
#(
  parameter int RCT_CUTOFF = 8,
  parameter int APT_WINDOW = 64,
  parameter int APT_CUTOFF = 20
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                strobe,
  input  logic                clear,
  output logic                rct_fail,
  output logic                apt_fail
);

  localparam int RCT_W     = $clog2(RCT_CUTOFF + 1);
  localparam int APT_IDX_W = $clog2(APT_WINDOW);
  localparam int APT_CNT_W = $clog2(APT_WINDOW + 1);

  logic [SAMPLE_W-1:0]  rct_prev;
  logic [SAMPLE_W-1:0]  apt_ref;
  logic [RCT_W-1:0]     rct_cnt;
  logic [RCT_W-1:0]     rct_cnt_nxt;
  logic [APT_IDX_W-1:0] apt_idx;
  logic [APT_CNT_W-1:0] apt_cnt;
  logic [APT_CNT_W-1:0] apt_cnt_nxt;

  // A zero repetition count marks "no previous sample", so the next one starts a run.
  always_comb begin
    rct_cnt_nxt = RCT_W'(1);
    if ((rct_cnt != '0) && (sample == rct_prev)) begin
      if (rct_cnt == RCT_W'(RCT_CUTOFF))
        rct_cnt_nxt = rct_cnt;
      else
        rct_cnt_nxt = rct_cnt + RCT_W'(1);
    end

    apt_cnt_nxt = apt_cnt;
    if (apt_idx == '0)
      apt_cnt_nxt = APT_CNT_W'(1);
    else if (sample == apt_ref)
      apt_cnt_nxt = apt_cnt + APT_CNT_W'(1);
  end

  assign rct_fail = strobe && (rct_cnt_nxt >= RCT_W'(RCT_CUTOFF));
  assign apt_fail = strobe && (apt_cnt_nxt >= APT_CNT_W'(APT_CUTOFF));

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      rct_prev <= '0;
      rct_cnt  <= '0;
      apt_ref  <= '0;
      apt_idx  <= '0;
      apt_cnt  <= '0;
    end else if (strobe) begin
      rct_prev <= sample;
      rct_cnt  <= rct_cnt_nxt;
      if (apt_idx == '0)
        apt_ref <= sample;
      apt_idx <= apt_idx + APT_IDX_W'(1);
      apt_cnt <= apt_cnt_nxt;
    end
  end

endmodule

// File: rtl/chaoent_health_pack.sv
// Health-gated packer: startup/run/fail FSM around the online tests, nibble
// packer and a single-entry valid/ready output register.
module chaoent_health_pack
  import chaoent_pkg::*;
#(
  parameter int OUT_WIDTH       = 32,
  parameter int RCT_CUTOFF      = 8,
  parameter int APT_WINDOW      = 64,
  parameter int APT_CUTOFF      = 20,
  parameter int STARTUP_SAMPLES = 128
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_en,
  input  logic [SAMPLE_W-1:0]  i_dat,
  input  logic                 i_valid,
  input  logic                 i_clr_fail,
  input  logic                 i_ready,
  output logic [OUT_WIDTH-1:0] o_word,
  output logic                 o_valid,
  output logic [1:0]           o_state,
  output logic                 o_rct_fail,
  output logic                 o_apt_fail,
  output logic                 o_overflow
);

  localparam int NIBS  = OUT_WIDTH / SAMPLE_W;
  localparam int NIB_W = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam int SU_W  = $clog2(STARTUP_SAMPLES + 1);

  chaoent_state_e state_q;
  chaoent_state_e state_d;

  logic                          accept;
  logic                          clr;
  logic                          rct_hit;
  logic                          apt_hit;
  logic                          any_fail;
  logic                          pack_now;
  logic                          word_done;
  logic                          load;
  logic [SU_W-1:0]               startup_cnt;
  logic [NIB_W-1:0]              nib_cnt;
  logic [OUT_WIDTH-SAMPLE_W-1:0] pack_sr;
  logic [OUT_WIDTH-1:0]          pack_in;

  assign accept    = i_en && i_valid && (state_q != ST_FAIL);
  assign clr       = i_en && i_clr_fail && (state_q == ST_FAIL);
  assign any_fail  = rct_hit || apt_hit;
  assign pack_now  = accept && (state_q == ST_RUN) && !any_fail;
  assign pack_in   = {pack_sr, i_dat};
  assign word_done = pack_now && (nib_cnt == NIB_W'(NIBS - 1));
  assign load      = word_done && (!o_valid || i_ready);
  assign o_state   = state_q;

  chaoent_health_test #(
    .RCT_CUTOFF (RCT_CUTOFF),
    .APT_WINDOW (APT_WINDOW),
    .APT_CUTOFF (APT_CUTOFF)
  ) u_health (
    .clk      (i_clk),
    .reset_n  (i_reset_n),
    .sample   (i_dat),
    .strobe   (accept),
    .clear    (clr),
    .rct_fail (rct_hit),
    .apt_fail (apt_hit)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n)
      state_q <= ST_STARTUP;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_STARTUP: begin
        if (any_fail)
          state_d = ST_FAIL;
        else if (accept && (startup_cnt == SU_W'(STARTUP_SAMPLES - 1)))
          state_d = ST_RUN;
      end
      ST_RUN: begin
        if (any_fail)
          state_d = ST_FAIL;
      end
      ST_FAIL: begin
        if (clr)
          state_d = ST_STARTUP;
      end
      default: state_d = ST_STARTUP;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || clr)
      startup_cnt <= '0;
    else if (accept && (state_q == ST_STARTUP) && !any_fail)
      startup_cnt <= startup_cnt + SU_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || clr) begin
      o_rct_fail <= 1'b0;
      o_apt_fail <= 1'b0;
    end else begin
      if (rct_hit)
        o_rct_fail <= 1'b1;
      if (apt_hit)
        o_apt_fail <= 1'b1;
    end
  end

  // A failure discards the partial word and any word waiting for the consumer;
  // o_word itself keeps its last contents.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      pack_sr    <= '0;
      nib_cnt    <= '0;
      o_word     <= '0;
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
    end else if (any_fail) begin
      pack_sr <= '0;
      nib_cnt <= '0;
      o_valid <= 1'b0;
    end else if (clr) begin
      pack_sr    <= '0;
      nib_cnt    <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (pack_now) begin
        pack_sr <= pack_in[OUT_WIDTH-SAMPLE_W-1:0];
        nib_cnt <= word_done ? '0 : nib_cnt + NIB_W'(1);
      end
      if (load) begin
        o_word  <= pack_in;
        o_valid <= 1'b1;
      end else begin
        if (word_done)
          o_overflow <= 1'b1;
        if (o_valid && i_ready)
          o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_chaoent_health_pack.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// history-based reference model of the health tests, FSM and packer.
module tb_chaoent_health_pack;

  localparam int OUT_WIDTH       = 32;
  localparam int RCT_CUTOFF      = 8;
  localparam int APT_WINDOW      = 64;
  localparam int APT_CUTOFF      = 20;
  localparam int STARTUP_SAMPLES = 128;
  localparam int NIBS            = OUT_WIDTH / 4;

  logic                 i_clk      = 1'b0;
  logic                 i_reset_n  = 1'b0;
  logic                 i_en       = 1'b0;
  logic [3:0]           i_dat      = 4'h0;
  logic                 i_valid    = 1'b0;
  logic                 i_clr_fail = 1'b0;
  logic                 i_ready    = 1'b0;
  logic [OUT_WIDTH-1:0] o_word;
  logic                 o_valid;
  logic [1:0]           o_state;
  logic                 o_rct_fail;
  logic                 o_apt_fail;
  logic                 o_overflow;

  int total = 0;
  int bad   = 0;

  // Reference model: samples accepted since the last reset/clear, nibbles of
  // the word being built, and the expected visible outputs.
  int                   hist[$];
  int                   nibq[$];
  int                   m_state;
  bit                   m_rct;
  bit                   m_apt;
  bit                   m_ovf;
  bit                   m_valid;
  logic [OUT_WIDTH-1:0] m_word;

  chaoent_health_pack #(
    .OUT_WIDTH       (OUT_WIDTH),
    .RCT_CUTOFF      (RCT_CUTOFF),
    .APT_WINDOW      (APT_WINDOW),
    .APT_CUTOFF      (APT_CUTOFF),
    .STARTUP_SAMPLES (STARTUP_SAMPLES)
  ) dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_en       (i_en),
    .i_dat      (i_dat),
    .i_valid    (i_valid),
    .i_clr_fail (i_clr_fail),
    .i_ready    (i_ready),
    .o_word     (o_word),
    .o_valid    (o_valid),
    .o_state    (o_state),
    .o_rct_fail (o_rct_fail),
    .o_apt_fail (o_apt_fail),
    .o_overflow (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [OUT_WIDTH-1:0] got,
                             input logic [OUT_WIDTH-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("state",    OUT_WIDTH'(o_state),    OUT_WIDTH'(m_state));
    checkOutput("valid",    OUT_WIDTH'(o_valid),    OUT_WIDTH'(m_valid));
    checkOutput("word",     o_word,                 m_word);
    checkOutput("rct_fail", OUT_WIDTH'(o_rct_fail), OUT_WIDTH'(m_rct));
    checkOutput("apt_fail", OUT_WIDTH'(o_apt_fail), OUT_WIDTH'(m_apt));
    checkOutput("overflow", OUT_WIDTH'(o_overflow), OUT_WIDTH'(m_ovf));
  endtask

  task automatic doReset();
    i_reset_n  = 1'b0;
    i_valid    = 1'b0;
    i_clr_fail = 1'b0;
    @(posedge i_clk);
    #1;
    hist.delete();
    nibq.delete();
    m_state = 0;
    m_rct   = 1'b0;
    m_apt   = 1'b0;
    m_ovf   = 1'b0;
    m_valid = 1'b0;
    m_word  = '0;
    checkAll();
    i_reset_n = 1'b1;
  endtask

  // Drives one cycle, advances the model by the rules, then checks after the edge.
  task automatic applyStimulus(input bit en, input bit valid, input logic [3:0] dat,
                               input bit ready, input bit clr);
    bit                   acc;
    bit                   handoff;
    bit                   fail;
    bit                   loaded;
    int                   run;
    int                   n;
    int                   ws;
    int                   cnt;
    logic [OUT_WIDTH-1:0] w;

    i_en       = en;
    i_valid    = valid;
    i_dat      = dat;
    i_ready    = ready;
    i_clr_fail = clr;

    handoff = m_valid && ready;
    loaded  = 1'b0;
    fail    = 1'b0;
    acc     = en && valid && (m_state != 2);

    if (acc) begin
      hist.push_back(int'(dat));
      run = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
        if (hist[i] != int'(dat)) break;
        run++;
      end
      n   = hist.size();
      ws  = ((n - 1) / APT_WINDOW) * APT_WINDOW;
      cnt = 0;
      for (int i = ws; i < n; i++)
        if (hist[i] == hist[ws]) cnt++;
      if (run >= RCT_CUTOFF) begin m_rct = 1'b1; fail = 1'b1; end
      if (cnt >= APT_CUTOFF) begin m_apt = 1'b1; fail = 1'b1; end

      if (fail) begin
        m_state = 2;
        m_valid = 1'b0;
        nibq.delete();
      end else if (m_state == 0) begin
        if (n == STARTUP_SAMPLES) m_state = 1;
      end else begin
        nibq.push_back(int'(dat));
        if (nibq.size() == NIBS) begin
          w = '0;
          foreach (nibq[i]) w = (w << 4) | OUT_WIDTH'(nibq[i]);
          if (!m_valid || ready) begin
            m_word  = w;
            m_valid = 1'b1;
            loaded  = 1'b1;
          end else begin
            m_ovf = 1'b1;
          end
          nibq.delete();
        end
      end
    end else if (clr && en && (m_state == 2)) begin
      m_state = 0;
      m_rct   = 1'b0;
      m_apt   = 1'b0;
      m_ovf   = 1'b0;
      hist.delete();
      nibq.delete();
    end

    if (handoff && !loaded) m_valid = 1'b0;

    @(posedge i_clk);
    #1;
    checkAll();
  endtask

  initial begin
    int alph;
    logic [3:0] x;

    $display("[TB] start");
    doReset();
    checkOutput("reset_word", o_word, '0);

    // Startup with a 0..15 ramp, then the first word 0x12345678.
    for (int i = 0; i < STARTUP_SAMPLES; i++) begin
      applyStimulus(1, 1, 4'(i % 16), 1, 0);
      if (i == STARTUP_SAMPLES - 2) checkOutput("still_startup", OUT_WIDTH'(o_state), 0);
    end
    checkOutput("enter_run", OUT_WIDTH'(o_state), 1);
    for (int i = 1; i <= 8; i++) applyStimulus(1, 1, 4'(i), 0, 0);
    checkOutput("first_valid", OUT_WIDTH'(o_valid), 1);
    checkOutput("first_word", o_word, 32'h12345678);
    applyStimulus(1, 0, 4'h0, 0, 0);
    applyStimulus(1, 0, 4'h0, 0, 0);
    checkOutput("held_word", o_word, 32'h12345678);
    applyStimulus(1, 0, 4'h0, 1, 0);
    checkOutput("taken_valid", OUT_WIDTH'(o_valid), 0);

    // Backpressure: second word dropped while the first is held.
    for (int i = 0; i < 16; i++) applyStimulus(1, 1, 4'((i * 7 + 3) % 16), 0, 0);
    checkOutput("bp_word", o_word, 32'h3A18F6D4);
    checkOutput("bp_valid", OUT_WIDTH'(o_valid), 1);
    checkOutput("bp_overflow", OUT_WIDTH'(o_overflow), 1);
    applyStimulus(1, 0, 4'h0, 1, 0);
    checkOutput("bp_drained", OUT_WIDTH'(o_valid), 0);

    // Hold a word, then an RCT failure must drop it.
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 4'(i), 0, 0);
    checkOutput("pre_rct_valid", OUT_WIDTH'(o_valid), 1);
    for (int i = 0; i < 8; i++) applyStimulus(1, 1, 4'hA, 0, 0);
    checkOutput("rct_flag", OUT_WIDTH'(o_rct_fail), 1);
    checkOutput("rct_state", OUT_WIDTH'(o_state), 2);
    checkOutput("rct_valid", OUT_WIDTH'(o_valid), 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 4'(i + 2), 1, 0);
    checkOutput("fail_sticky", OUT_WIDTH'(o_state), 2);

    // Recovery: clear, restart, no output until 128 + 8 samples.
    applyStimulus(1, 0, 4'h0, 1, 1);
    checkOutput("clr_state", OUT_WIDTH'(o_state), 0);
    checkOutput("clr_rct", OUT_WIDTH'(o_rct_fail), 0);
    checkOutput("clr_ovf", OUT_WIDTH'(o_overflow), 0);
    for (int i = 0; i < STARTUP_SAMPLES + 8; i++) begin
      applyStimulus(1, 1, 4'(i % 16), 0, 0);
      if (i == STARTUP_SAMPLES + 6) checkOutput("rec_no_valid", OUT_WIDTH'(o_valid), 0);
    end
    checkOutput("rec_valid", OUT_WIDTH'(o_valid), 1);
    checkOutput("rec_word", o_word, 32'h01234567);

    // APT: window starting with 3, 3 every third sample; 20th match at index 57.
    doReset();
    for (int k = 0; k < 58; k++) begin
      if (k % 3 == 0)      x = 4'h3;
      else if (k % 3 == 1) x = 4'(4 + (k / 3) % 6);
      else                 x = 4'(10 + (k / 3) % 6);
      applyStimulus(1, 1, x, 1, 0);
      if (k == 56) checkOutput("apt_not_yet", OUT_WIDTH'(o_apt_fail), 0);
    end
    checkOutput("apt_flag", OUT_WIDTH'(o_apt_fail), 1);
    checkOutput("apt_no_rct", OUT_WIDTH'(o_rct_fail), 0);
    checkOutput("apt_state", OUT_WIDTH'(o_state), 2);

    // Reset in the middle of a word.
    doReset();
    for (int i = 0; i < STARTUP_SAMPLES; i++) applyStimulus(1, 1, 4'(i % 16), 1, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 4'(9 + i), 1, 0);
    doReset();
    checkOutput("midreset_state", OUT_WIDTH'(o_state), 0);
    for (int i = 0; i < STARTUP_SAMPLES + 8; i++) applyStimulus(1, 1, 4'(i % 16), 1, 0);
    checkOutput("midreset_word", o_word, 32'h01234567);

    // Randomized traffic with varying alphabet sizes to provoke failures.
    for (int ph = 0; ph < 3; ph++) begin
      doReset();
      alph = (ph == 0) ? 16 : (ph == 1) ? 2 : 4;
      for (int c = 0; c < 3000; c++)
        applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
                      4'($urandom_range(0, alph - 1)), $urandom_range(0, 1) == 1,
                      $urandom_range(0, 19) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
